controller_interface: RTL and testbench

Serial game-pad reader for the GBC top level. It periodically latches an external NES-style shift-register controller, clocks out its eight button bits, and presents them as a stable, active-high byte to the joypad I/O register logic. The block is free-running: no handshake with the CPU, and it runs on the 33 MHz system clock.

---
 rtl/controller_interface_pkg.sv | 31 +++
 rtl/controller_interface_if.sv | 16 +
 rtl/controller_interface_sync2.sv | 31 +++
 rtl/controller_interface.sv | 135 +++++++++++++
 tb/tb_controller_interface.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/controller_interface_pkg.sv
// rtl/controller_interface_pkg.sv - shared types and constants for the game-pad reader
// Purpose: FSM state encoding, button bit positions within O_BUTTONS, and the
//          default timing constants for a 33 MHz system clock.
// Ports:   none (package).
package controller_interface_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_PULSE_HI,
    ST_PULSE_LO
  } state_e;

  // Bit positions of each button in O_BUTTONS; also the serial order on I_DATA.
  typedef enum logic [2:0] {
    BTN_A,
    BTN_B,
    BTN_SELECT,
    BTN_START,
    BTN_UP,
    BTN_DOWN,
    BTN_LEFT,
    BTN_RIGHT
  } btn_e;

  localparam int NUM_BUTTONS           = 8;
  localparam int DEF_LATCH_CYCLES      = 396;     // 12 us
  localparam int DEF_HALF_PULSE_CYCLES = 198;     // 6 us
  localparam int DEF_POLL_CYCLES       = 550000;  // ~60 Hz frame

endpackage

// File: rtl/controller_interface_if.sv
// rtl/controller_interface_if.sv - pad-side signals of the NES-style controller
// Purpose: groups the serial link to the external shift-register controller.
// Ports:   I_DATA  - serial button data from the pad (low = pressed)
//          O_LATCH - latch strobe to the pad, active-high
//          O_PULSE - shift clock to the pad, active-high
// Modports: master = reader (drives latch/pulse), slave = pad (drives data).
interface controller_interface_if;

  logic I_DATA;
  logic O_LATCH;
  logic O_PULSE;

  modport master (input I_DATA, output O_LATCH, output O_PULSE);
  modport slave  (output I_DATA, input O_LATCH, input O_PULSE);

endinterface

// File: rtl/controller_interface_sync2.sv
// rtl/controller_interface_sync2.sv - two-flop synchronizer for one asynchronous bit
// Purpose: brings an asynchronous level into the clock domain with 2 cycles latency.
// Ports:   clk_i  - clock
//          rst_ni - asynchronous active-low reset (flops load RESET_VAL)
//          d_i    - asynchronous input
//          q_o    - synchronized output
module controller_interface_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/controller_interface.sv
// rtl/controller_interface.sv - free-running serial game-pad reader
// Purpose: once per frame latches the pad, clocks out 8 button bits and presents
//          them as an active-high byte, updated atomically at the end of the read.
// Ports:   I_CLK_33MHZ - system clock, rising edge
//          I_RESET_L   - asynchronous active-low reset
//          pad         - controller link (I_DATA in, O_LATCH / O_PULSE out)
//          O_BUTTONS   - 1 = pressed; bit order A,B,Select,Start,Up,Down,Left,Right
module controller_interface
  import controller_interface_pkg::*;
#(
  parameter int LATCH_CYCLES      = DEF_LATCH_CYCLES,
  parameter int HALF_PULSE_CYCLES = DEF_HALF_PULSE_CYCLES,
  parameter int POLL_CYCLES       = DEF_POLL_CYCLES
) (
  input  logic                     I_CLK_33MHZ,
  input  logic                     I_RESET_L,
  controller_interface_if.master   pad,
  output logic [NUM_BUTTONS-1:0]   O_BUTTONS
);

  localparam int PHASE_MAX = (LATCH_CYCLES > HALF_PULSE_CYCLES) ? LATCH_CYCLES : HALF_PULSE_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int FRAME_W   = $clog2(POLL_CYCLES);

  localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_PULSE_CYCLES - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(POLL_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [FRAME_W-1:0]      frame_q, frame_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [NUM_BUTTONS-1:0]  shift_q, shift_d;
  logic [NUM_BUTTONS-1:0]  buttons_q, buttons_d;
  logic                    latch_q, latch_d;
  logic                    pulse_q, pulse_d;
  logic                    data_s;

  controller_interface_sync2 #(.RESET_VAL(1'b1)) u_sync2 (
    .clk_i  (I_CLK_33MHZ),
    .rst_ni (I_RESET_L),
    .d_i    (pad.I_DATA),
    .q_o    (data_s)
  );

  // Frame counter is independent of the FSM so the frame period stays exact.
  always_comb begin
    frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_q == '0) begin
          state_d   = ST_LATCH;
          phase_d   = '0;
          bit_idx_d = 3'd0;
          shift_d   = '0;
        end
      end
      ST_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          // A is already driven by the pad while the latch is high.
          shift_d[BTN_A] = ~data_s;
          state_d        = ST_PULSE_HI;
          phase_d        = '0;
          bit_idx_d      = 3'd1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_PULSE_HI: begin
        if (phase_q == HALF_LAST) begin
          state_d = ST_PULSE_LO;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_PULSE_LO: begin
        if (phase_q == HALF_LAST) begin
          shift_d[bit_idx_q] = ~data_s;
          phase_d            = '0;
          if (bit_idx_q == BTN_RIGHT) begin
            // Publish the full byte, including the bit captured this cycle.
            buttons_d = shift_d;
            state_d   = ST_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            state_d   = ST_PULSE_HI;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Strobes decoded from the next state and registered, so they are glitch-free
    // and mutually exclusive.
    latch_d = (state_d == ST_LATCH);
    pulse_d = (state_d == ST_PULSE_HI);
  end

  always_ff @(posedge I_CLK_33MHZ or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      phase_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= '0;
      buttons_q <= '0;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      latch_q   <= latch_d;
      pulse_q   <= pulse_d;
    end
  end

  assign pad.O_LATCH = latch_q;
  assign pad.O_PULSE = pulse_q;
  assign O_BUTTONS   = buttons_q;

endmodule

// File: tb/tb_controller_interface.sv
// tb/tb_controller_interface.sv - directed self-checking bench for controller_interface
module tb_controller_interface;

  logic       clk;
  logic       rst_n;
  logic       rst2_n;
  logic [7:0] buttons;
  logic [7:0] buttons_d;

  int errors = 0;
  int checks = 0;

  logic [7:0] pad_pat;
  logic [7:0] pad_sr;
  logic       prev_latch;
  logic       prev_pulse;
  logic [7:0] pats [12];

  controller_interface_if pad ();
  controller_interface_if pad_d ();

  controller_interface #(
    .LATCH_CYCLES      (4),
    .HALF_PULSE_CYCLES (2),
    .POLL_CYCLES       (40)
  ) u_dut (
    .I_CLK_33MHZ (clk),
    .I_RESET_L   (rst_n),
    .pad         (pad),
    .O_BUTTONS   (buttons)
  );

  controller_interface u_dut_def (
    .I_CLK_33MHZ (clk),
    .I_RESET_L   (rst2_n),
    .pad         (pad_d),
    .O_BUTTONS   (buttons_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad model: parallel load on latch, shift toward bit 0 on each pulse,
  // output is the inverted (active-low) bit 0.
  initial begin
    pad_sr     = 8'h00;
    pad.I_DATA = 1'b1;
    forever begin
      @(posedge pad.O_LATCH or posedge pad.O_PULSE);
      #1;
      if (pad.O_LATCH) pad_sr = pad_pat;
      else if (pad.O_PULSE) pad_sr = {1'b0, pad_sr[7:1]};
      pad.I_DATA = ~pad_sr[0];
    end
  end

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic exp_latch(input int f, input int l);
    return f < l;
  endfunction

  function automatic logic exp_pulse(input int f, input int l, input int h);
    return (f >= l) && (f < l + 14 * h) && (((f - l) % (2 * h)) < h);
  endfunction

  // Runs ncyc cycles of a frame of the small DUT starting at latch rise.
  task automatic run_cycles(input int ncyc, input logic [7:0] b_before, input logic [7:0] b_after,
                            input bit set_next, input logic [7:0] next_pat);
    int lr = 0;
    int pr = 0;
    for (int f = 0; f < ncyc; f++) begin
      @(negedge clk);
      if (set_next && f == 10) pad_pat = next_pat;
      chk("latch", f, 32'(pad.O_LATCH), 32'(exp_latch(f, 4)));
      chk("pulse", f, 32'(pad.O_PULSE), 32'(exp_pulse(f, 4, 2)));
      chk("buttons", f, 32'(buttons), 32'((f >= 32) ? b_after : b_before));
      if (pad.O_LATCH && !prev_latch) lr++;
      if (pad.O_PULSE && !prev_pulse) pr++;
      prev_latch = pad.O_LATCH;
      prev_pulse = pad.O_PULSE;
    end
    if (ncyc == 40) begin
      chk("latch_count", ncyc, 32'(lr), 32'd1);
      chk("pulse_count", ncyc, 32'(pr), 32'd7);
    end
  endtask

  initial begin
    int dl_rises;
    int dp_rises;
    logic dprev_l;
    logic dprev_p;

    pats = '{8'h00, 8'h00, 8'h08, 8'h08, 8'h89, 8'h89, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3C};
    rst_n        = 1'b0;
    rst2_n       = 1'b0;
    pad_pat      = pats[0];
    pad_d.I_DATA = 1'b1;
    prev_latch   = 1'b0;
    prev_pulse   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_latch", 0, 32'(pad.O_LATCH), 32'd0);
    chk("rst_pulse", 0, 32'(pad.O_PULSE), 32'd0);
    chk("rst_buttons", 0, 32'(buttons), 32'd0);
    rst_n = 1'b1;

    // Frames 0..10: idle, Start only, 0x89 pattern changed mid-frame, others.
    for (int fr = 0; fr < 11; fr++) begin
      run_cycles(40, (fr == 0) ? 8'h00 : pats[fr-1], pats[fr], 1'b1, pats[fr+1]);
    end

    // Partial frame up to mid-pulse, then asynchronous reset.
    run_cycles(6, pats[10], pats[10], 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("async_latch", 6, 32'(pad.O_LATCH), 32'd0);
    chk("async_pulse", 6, 32'(pad.O_PULSE), 32'd0);
    chk("async_buttons", 6, 32'(buttons), 32'd0);
    repeat (3) @(negedge clk);
    chk("hold_pulse", 0, 32'(pad.O_PULSE), 32'd0);
    chk("hold_buttons", 0, 32'(buttons), 32'd0);
    prev_latch = 1'b0;
    prev_pulse = 1'b0;
    rst_n = 1'b1;
    run_cycles(40, 8'h00, pats[11], 1'b0, 8'h00);

    // Default timing instance, first frame only.
    dl_rises = 0;
    dp_rises = 0;
    dprev_l  = 1'b0;
    dprev_p  = 1'b0;
    rst2_n   = 1'b1;
    for (int t = 0; t < 3400; t++) begin
      @(negedge clk);
      chk("def_latch", t, 32'(pad_d.O_LATCH), 32'(exp_latch(t, 396)));
      chk("def_pulse", t, 32'(pad_d.O_PULSE), 32'(exp_pulse(t, 396, 198)));
      if (t == 3167 || t == 3168 || t == 3399) chk("def_buttons", t, 32'(buttons_d), 32'd0);
      if (pad_d.O_LATCH && !dprev_l) dl_rises++;
      if (pad_d.O_PULSE && !dprev_p) dp_rises++;
      dprev_l = pad_d.O_LATCH;
      dprev_p = pad_d.O_PULSE;
    end
    chk("def_latch_count", 3400, 32'(dl_rises), 32'd1);
    chk("def_pulse_count", 3400, 32'(dp_rises), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
